// File: rtl/nd2_input_filter_if.sv
// nd2_input_filter_if: handshake bundle for the ND2 input-conditioning stage.
// Carries enable, raw inputs and the conditioned output/status signals.
// GCNT (and CNT_W) exist only when ND2_GLITCH_CNT_EN is defined.
interface nd2_input_filter_if
`ifdef ND2_GLITCH_CNT_EN
  #(parameter int CNT_W = 8)
`endif
  ;
  logic CE;
  logic A;
  logic B;
  logic Z;
  logic ZV;
  logic ZCHG;
`ifdef ND2_GLITCH_CNT_EN
  logic [CNT_W-1:0] GCNT;

  modport master (output CE, A, B, input Z, ZV, ZCHG, GCNT);
  modport slave  (input CE, A, B, output Z, ZV, ZCHG, GCNT);
`else
  modport master (output CE, A, B, input Z, ZV, ZCHG);
  modport slave  (input CE, A, B, output Z, ZV, ZCHG);
`endif
endinterface

// File: rtl/nd2_input_filter.sv
// nd2_input_filter: synchronise + debounce two raw inputs, drive a registered
// NAND of the accepted levels, plus output-valid and output-change status.
// Optional feature macro: ND2_GLITCH_CNT_EN (adds CNT_W parameter, GCNT output
// and the saturating rejected-glitch counter).

// Per-input lane: free-running synchroniser followed by a CE-gated debounce filter.
module nd2_filt_lane #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4
) (
  input  logic CK,
  input  logic CD,
  input  logic ce,
  input  logic raw,
  output logic filt
`ifdef ND2_GLITCH_CNT_EN
  ,
  output logic glitch
`endif
);
  localparam int CW = $clog2(FILT_CYC + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // Synchroniser chain: ignores CE, only CD clears it.
  always_ff @(posedge CK) begin
    if (CD) sync_q <= '0;
    else    sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  end

  // Debounce: a new level must differ for FILT_CYC enabled cycles in a row.
  always_ff @(posedge CK) begin
    if (CD) begin
      filt <= 1'b0;
      cnt  <= '0;
    end else if (ce) begin
      if (sync == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_CYC - 1)) begin
        filt <= sync;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef ND2_GLITCH_CNT_EN
  // A partial count abandoned because the input returned is one rejected glitch.
  assign glitch = ce && (sync == filt) && (cnt != '0);
`endif
endmodule

// Top: two filter lanes, registered NAND output, warm-up and glitch status.
module nd2_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4
`ifdef ND2_GLITCH_CNT_EN
  ,
  parameter int CNT_W       = 8
`endif
) (
  input logic               CK,
  input logic               CD,
  nd2_input_filter_if.slave bus
);
  localparam int NUM_LANES = 2;
  localparam int WARM      = SYNC_STAGES + FILT_CYC;
  localparam int WW        = $clog2(WARM + 1);

  logic [NUM_LANES-1:0] raw;
  logic [NUM_LANES-1:0] filt;
  logic                 z_nxt;
  logic                 z_q;
  logic                 zchg_q;
  logic                 zv_q;
  logic [WW-1:0]        wcnt;

  assign raw = {bus.B, bus.A};

`ifdef ND2_GLITCH_CNT_EN
  localparam int GW = CNT_W + 1;
  logic [NUM_LANES-1:0] glitch;
  logic [CNT_W-1:0]     gcnt;
  logic [GW-1:0]        gsum;

  nd2_filt_lane #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_lane [NUM_LANES-1:0] (
    .CK(CK), .CD(CD), .ce(bus.CE), .raw(raw), .filt(filt), .glitch(glitch)
  );
`else
  nd2_filt_lane #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) u_lane [NUM_LANES-1:0] (
    .CK(CK), .CD(CD), .ce(bus.CE), .raw(raw), .filt(filt)
  );
`endif

  // Z is taken from the registered accepted levels, one stage after acceptance.
  assign z_nxt = ~&filt;

  // Output register and change pulse; the pulse only fires on a real value change.
  always_ff @(posedge CK) begin
    if (CD) begin
      z_q    <= 1'b1;
      zchg_q <= 1'b0;
    end else if (bus.CE) begin
      z_q    <= z_nxt;
      zchg_q <= (z_nxt != z_q);
    end else begin
      zchg_q <= 1'b0;
    end
  end

  // Warm-up: ZV rises on the WARM-th enabled edge after reset and sticks.
  always_ff @(posedge CK) begin
    if (CD) begin
      wcnt <= '0;
      zv_q <= 1'b0;
    end else if (bus.CE && !zv_q) begin
      if (wcnt == WW'(WARM - 1)) zv_q <= 1'b1;
      else                       wcnt <= wcnt + 1'b1;
    end
  end

  assign bus.Z    = z_q;
  assign bus.ZV   = zv_q;
  assign bus.ZCHG = zchg_q;

`ifdef ND2_GLITCH_CNT_EN
  // Both lanes can reject on the same edge, so add up to two per cycle.
  assign gsum = {1'b0, gcnt} + GW'(glitch[0]) + GW'(glitch[1]);

  // Saturating glitch counter, cleared only by CD.
  always_ff @(posedge CK) begin
    if (CD)                gcnt <= '0;
    else if (gsum[CNT_W])  gcnt <= '1;
    else                   gcnt <= gsum[CNT_W-1:0];
  end

  assign bus.GCNT = gcnt;
`endif
endmodule

// File: tb/tb_nd2_input_filter.sv
// tb_nd2_input_filter: directed steps plus random stimulus, each edge checked
// against a delay-line / run-length reference model.
module tb_nd2_input_filter;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_CYC    = 4;
  localparam int WARM        = SYNC_STAGES + FILT_CYC;
`ifdef ND2_GLITCH_CNT_EN
  localparam int CNT_W       = 2;
  localparam int GMAX        = (1 << CNT_W) - 1;
`endif

  logic CK = 1'b0;
  logic CD = 1'b1;

`ifdef ND2_GLITCH_CNT_EN
  nd2_input_filter_if #(.CNT_W(CNT_W)) bus ();
  nd2_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC), .CNT_W(CNT_W)) dut (
    .CK(CK), .CD(CD), .bus(bus.slave)
  );
`else
  nd2_input_filter_if bus ();
  nd2_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYC(FILT_CYC)) dut (
    .CK(CK), .CD(CD), .bus(bus.slave)
  );
`endif

  always #5 CK = ~CK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic dq_a[$];
  logic dq_b[$];
  logic m_filt[2];
  int   m_run[2];
  logic m_z, m_zchg, m_zv;
  int   m_ce_edges;
  int   m_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One filter lane: s is the input as seen SYNC_STAGES edges late.
  task automatic mdl_lane(input int i, input logic s, inout int g);
    if (s == m_filt[i]) begin
      if (m_run[i] > 0) g++;
      m_run[i] = 0;
    end else if (m_run[i] + 1 >= FILT_CYC) begin
      m_filt[i] = s;
      m_run[i]  = 0;
    end else begin
      m_run[i]++;
    end
  endtask

  task automatic mdl(input logic cd, input logic ce, input logic a, input logic b);
    logic sa, sb, zn;
    int g;
    if (cd) begin
      dq_a.delete(); dq_b.delete();
      for (int i = 0; i < SYNC_STAGES; i++) begin
        dq_a.push_back(1'b0); dq_b.push_back(1'b0);
      end
      m_filt[0] = 0; m_filt[1] = 0; m_run[0] = 0; m_run[1] = 0;
      m_z = 1; m_zchg = 0; m_zv = 0; m_ce_edges = 0; m_g = 0;
      return;
    end
    sa = dq_a.pop_front(); dq_a.push_back(a);
    sb = dq_b.pop_front(); dq_b.push_back(b);
    if (ce) begin
      zn = ~(m_filt[0] & m_filt[1]);
      m_zchg = (zn != m_z);
      m_z = zn;
      m_ce_edges++;
      if (m_ce_edges >= WARM) m_zv = 1;
      g = 0;
      mdl_lane(0, sa, g);
      mdl_lane(1, sb, g);
      m_g = m_g + g;
`ifdef ND2_GLITCH_CNT_EN
      if (m_g > GMAX) m_g = GMAX;
`endif
    end else begin
      m_zchg = 0;
    end
  endtask

  task automatic step(input logic cd, input logic ce, input logic a, input logic b);
    CD = cd; bus.CE = ce; bus.A = a; bus.B = b;
    @(posedge CK);
    mdl(cd, ce, a, b);
    #1;
    chk("mdl_z", 32'(bus.Z), 32'(m_z));
    chk("mdl_zv", 32'(bus.ZV), 32'(m_zv));
    chk("mdl_zchg", 32'(bus.ZCHG), 32'(m_zchg));
`ifdef ND2_GLITCH_CNT_EN
    chk("mdl_gcnt", 32'(bus.GCNT), 32'(m_g));
`endif
  endtask

  initial begin
    bus.CE = 1'b1; bus.A = 1'b0; bus.B = 1'b0;

    // 1: reset then warm-up
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0, 0);
      chk("t1_rst_z", 32'(bus.Z), 1);
      chk("t1_rst_zv", 32'(bus.ZV), 0);
      chk("t1_rst_zchg", 32'(bus.ZCHG), 0);
`ifdef ND2_GLITCH_CNT_EN
      chk("t1_rst_gcnt", 32'(bus.GCNT), 0);
`endif
    end
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, 0, 0);
      chk("t1_zv", 32'(bus.ZV), 32'(k >= WARM));
      chk("t1_z", 32'(bus.Z), 1);
      chk("t1_zchg", 32'(bus.ZCHG), 0);
    end

    // 2: clean rise on both inputs, Z falls 7 edges later
    for (int k = 1; k <= 9; k++) begin
      step(0, 1, 1, 1);
      chk("t2_z", 32'(bus.Z), 32'(k < 7));
      chk("t2_zchg", 32'(bus.ZCHG), 32'(k == 7));
    end

    // 3: 3-cycle low glitch on A is rejected
    for (int k = 1; k <= 13; k++) begin
      step(0, 1, (k > 3), 1);
      chk("t3_z", 32'(bus.Z), 0);
      chk("t3_zchg", 32'(bus.ZCHG), 0);
    end
`ifdef ND2_GLITCH_CNT_EN
    chk("t3_gcnt", 32'(bus.GCNT), 1);
`endif

    // 4: A=1,B=0 settles at Z=1, then swap both on one edge
    for (int k = 1; k <= 12; k++) step(0, 1, 1, 0);
    chk("t4_pre_z", 32'(bus.Z), 1);
    for (int k = 1; k <= 12; k++) begin
      step(0, 1, 0, 1);
      chk("t4_z", 32'(bus.Z), 1);
      chk("t4_zchg", 32'(bus.ZCHG), 0);
    end

    // 5a: CE low for 5 cycles mid-filter delays the fall to t0+12
    for (int k = 1; k <= 14; k++) begin
      step(0, !(k >= 3 && k <= 7), 1, 1);
      chk("t5_z", 32'(bus.Z), 32'(k < 12));
      chk("t5_zchg", 32'(bus.ZCHG), 32'(k == 12));
    end
    for (int k = 1; k <= 12; k++) step(0, 1, 0, 1);
    chk("t5_back_z", 32'(bus.Z), 1);

    // 5b: CD mid-filter discards the pending change
    for (int k = 1; k <= 3; k++) step(0, 1, 1, 1);
    step(1, 1, 1, 1);
    chk("t5_cd_z", 32'(bus.Z), 1);
    chk("t5_cd_zv", 32'(bus.ZV), 0);
    for (int k = 5; k <= 10; k++) begin
      step(0, 1, 1, 1);
      chk("t5_lost_z", 32'(bus.Z), 1);
    end

`ifdef ND2_GLITCH_CNT_EN
    // 6: isolated 2-cycle glitches on B saturate GCNT
    step(1, 1, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 1, 0, 0);
    for (int gi = 0; gi < 5; gi++) begin
      step(0, 1, 0, 1);
      step(0, 1, 0, 1);
      for (int k = 0; k < 6; k++) step(0, 1, 0, 0);
      chk("t6_gcnt", 32'(bus.GCNT), 32'((gi + 1 > GMAX) ? GMAX : gi + 1));
    end
    step(1, 1, 0, 0);
    chk("t6_cd_gcnt", 32'(bus.GCNT), 0);
`endif

    // Random: held levels of random length, sparse CE drops and resets
    begin
      logic ra, rb;
      int   hold;
      ra = 0; rb = 0; hold = 0;
      for (int k = 0; k < 1500; k++) begin
        if (hold == 0) begin
          ra = 1'($urandom_range(1, 0));
          rb = 1'($urandom_range(1, 0));
          hold = $urandom_range(8, 1);
        end
        hold--;
        step(($urandom_range(99, 0) == 0), ($urandom_range(7, 0) != 0), ra, rb);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
